piece_lock: RTL and testbench

Upstream of the line-clear stage. When the active tetromino lands, this block merges its 4x4 cell mask into the settled board, one mask row per cycle, and presents the updated board as `stored_array`, which the line-clear stage consumes. It also reports three per-lock flags: overlap with settled cells, cells outside the side or bottom walls, and cells above the top row (top-out). The game FSM issues a lock request on entering LANDED and waits for `lock_done` before moving to EVAL.

---
 rtl/tetris_pkg.sv | 17 +
 rtl/piece_lock_if.sv | 29 ++
 rtl/piece_lock_row_merge.sv | 33 +++
 rtl/piece_lock.sv | 124 ++++++++++++
 tb/tb_piece_lock.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: board geometry, game FSM states and the lock-stage state encoding.
package tetris_pkg;

  localparam int ROWS = 20;
  localparam int COLS = 10;

  typedef enum logic [2:0] {
    INIT, SPAWN, FALLING, ROTATE, STUCK, LANDED, EVAL, GAMEOVER
  } game_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    DONE  = 2'd2
  } lock_state_t;

endpackage

// File: rtl/piece_lock_if.sv
// Bundle between the game FSM (master) and the piece lock stage (slave).
interface piece_lock_if;
  import tetris_pkg::*;

  // lock_req/lock_ready: a lock is accepted on a rising edge where both are 1;
  // the piece and board fields must be valid on that edge and are not used afterwards.
  logic                       lock_req;
  logic                       lock_ready;
  logic [3:0][3:0]            piece_mask;
  logic signed [5:0]          piece_row;
  logic signed [4:0]          piece_col;
  logic [ROWS-1:0][COLS-1:0]  board_in;
  logic [ROWS-1:0][COLS-1:0]  stored_array;
  logic                       lock_done;
  logic                       overlap_err;
  logic                       oob_err;
  logic                       topout;

  modport master (
    output lock_req, piece_mask, piece_row, piece_col, board_in,
    input  lock_ready, stored_array, lock_done, overlap_err, oob_err, topout
  );

  modport slave (
    input  lock_req, piece_mask, piece_row, piece_col, board_in,
    output lock_ready, stored_array, lock_done, overlap_err, oob_err, topout
  );

endinterface

// File: rtl/piece_lock_row_merge.sv
// Combinational merge of one 4-cell mask nibble into one board row at a signed column offset.
module row_merge
  import tetris_pkg::*;
(
  input  logic [COLS-1:0]   row_in,
  input  logic [3:0]        nibble,
  input  logic signed [4:0] piece_col,
  output logic [COLS-1:0]   row_out,
  output logic              overlap,
  output logic              oob
);

  logic signed [6:0] col;

  always_comb begin
    row_out = row_in;
    overlap = 1'b0;
    oob     = 1'b0;
    col     = '0;
    for (int c = 0; c < 4; c++) begin
      col = {{2{piece_col[4]}}, piece_col} + 7'(c);
      if (nibble[c]) begin
        if (col < 7'sd0 || col >= 7'(COLS)) begin
          oob = 1'b1;
        end else begin
          if (row_in[col[3:0]]) overlap = 1'b1;
          row_out[col[3:0]] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/piece_lock.sv
// Merges a landed 4x4 piece into the settled board one mask row per cycle and
// reports overlap, wall and top-out flags for the line-clear stage.
module piece_lock
  import tetris_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  piece_lock_if.slave       bus,
  output lock_state_t       state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MERGE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]                state;
  logic [1:0]                ri;
  logic [3:0][3:0]           mask_q;
  logic signed [5:0]         prow_q;
  logic signed [4:0]         pcol_q;
  logic [ROWS-1:0][COLS-1:0] work;
  logic [ROWS-1:0][COLS-1:0] work_next;
  logic [ROWS-1:0][COLS-1:0] stored_q;
  logic                      ov_w, oob_w, top_w;
  logic                      ov_q, oob_q, top_q;

  logic signed [6:0] trow;
  logic              row_neg, row_hi, row_ok;
  logic [4:0]        row_sel;
  logic [3:0]        nib;
  logic [COLS-1:0]   merged;
  logic              row_ovl, col_oob;
  logic              ov_n, oob_n, top_n;

  // Target row decode; out-of-range rows still feed the column check so a
  // cell above the top and outside a wall raises both flags.
  always_comb begin
    trow    = {prow_q[5], prow_q} + {5'b0, ri};
    row_neg = trow < 7'sd0;
    row_hi  = !row_neg && (trow >= 7'(ROWS));
    row_ok  = !row_neg && !row_hi;
    row_sel = row_ok ? trow[4:0] : 5'd0;
    nib     = mask_q[ri];
  end

  row_merge u_row_merge (
    .row_in    (work[row_sel]),
    .nibble    (nib),
    .piece_col (pcol_q),
    .row_out   (merged),
    .overlap   (row_ovl),
    .oob       (col_oob)
  );

  always_comb begin
    work_next = work;
    if (row_ok) work_next[row_sel] = merged;
    ov_n  = ov_w  | (row_ok & row_ovl);
    oob_n = oob_w | col_oob | (row_hi & (|nib));
    top_n = top_w | (row_neg & (|nib));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      ri       <= '0;
      mask_q   <= '0;
      prow_q   <= '0;
      pcol_q   <= '0;
      work     <= '0;
      stored_q <= '0;
      ov_w     <= 1'b0;
      oob_w    <= 1'b0;
      top_w    <= 1'b0;
      ov_q     <= 1'b0;
      oob_q    <= 1'b0;
      top_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.lock_req) begin
            mask_q <= bus.piece_mask;
            prow_q <= bus.piece_row;
            pcol_q <= bus.piece_col;
            work   <= bus.board_in;
            ri     <= '0;
            ov_w   <= 1'b0;
            oob_w  <= 1'b0;
            top_w  <= 1'b0;
            ov_q   <= 1'b0;
            oob_q  <= 1'b0;
            top_q  <= 1'b0;
            state  <= S_MERGE;
          end
        end
        S_MERGE: begin
          work  <= work_next;
          ov_w  <= ov_n;
          oob_w <= oob_n;
          top_w <= top_n;
          ri    <= ri + 2'd1;
          if (ri == 2'd3) begin
            stored_q <= work_next;
            ov_q     <= ov_n;
            oob_q    <= oob_n;
            top_q    <= top_n;
            state    <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.lock_ready   = (state == S_IDLE);
  assign bus.lock_done    = (state == S_DONE);
  assign bus.stored_array = stored_q;
  assign bus.overlap_err  = ov_q;
  assign bus.oob_err      = oob_q;
  assign bus.topout       = top_q;
  assign state_dbg        = lock_state_t'(state);

endmodule

// File: tb/tb_piece_lock.sv
// Directed bench for piece_lock: table of lock vectors plus reset, re-request and board-change sequences.
module tb_piece_lock;
  import tetris_pkg::*;

  typedef logic [ROWS-1:0][COLS-1:0] board_t;

  typedef struct {
    string             name;
    logic [3:0][3:0]   mask;
    logic signed [5:0] prow;
    logic signed [4:0] pcol;
    board_t            board;
    board_t            exp_board;
    logic              exp_ov;
    logic              exp_oob;
    logic              exp_top;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  lock_state_t state_dbg;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        vecs[8];

  piece_lock_if bus();

  piece_lock dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_board(input string name, input board_t act, input board_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [3:0][3:0] m,
                              input logic signed [5:0] r, input logic signed [4:0] c,
                              input board_t b, input board_t e,
                              input logic ov, input logic oob, input logic top);
    vec_t v;
    v.name = name; v.mask = m; v.prow = r; v.pcol = c;
    v.board = b; v.exp_board = e;
    v.exp_ov = ov; v.exp_oob = oob; v.exp_top = top;
    return v;
  endfunction

  // Drive one lock and return the number of edges after accept until lock_done (0 = timeout).
  task automatic run_lock(input vec_t v, input bit scramble, input bit poke_req, output int lat);
    bus.piece_mask = v.mask;
    bus.piece_row  = v.prow;
    bus.piece_col  = v.pcol;
    bus.board_in   = v.board;
    chk({v.name, " ready_before"}, 32'(bus.lock_ready), 32'd1);
    bus.lock_req = 1'b1;
    @(posedge clk); #1;
    bus.lock_req = 1'b0;
    if (scramble) bus.board_in = '1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      bus.lock_req = (poke_req && i == 2);
      @(posedge clk); #1;
      if (bus.lock_done) begin
        lat = i;
        break;
      end
    end
    bus.lock_req = 1'b0;
  endtask

  task automatic check_result(input vec_t v, input int lat);
    chk({v.name, " latency"}, 32'(lat), 32'd4);
    chk_board({v.name, " board"}, bus.stored_array, v.exp_board);
    chk({v.name, " overlap"}, 32'(bus.overlap_err), 32'(v.exp_ov));
    chk({v.name, " oob"}, 32'(bus.oob_err), 32'(v.exp_oob));
    chk({v.name, " topout"}, 32'(bus.topout), 32'(v.exp_top));
    @(posedge clk); #1;
    chk({v.name, " done_pulse"}, 32'(bus.lock_done), 32'd0);
    chk({v.name, " ready_after"}, 32'(bus.lock_ready), 32'd1);
    chk({v.name, " flags_hold"}, {29'd0, bus.overlap_err, bus.oob_err, bus.topout},
        {29'd0, v.exp_ov, v.exp_oob, v.exp_top});
    chk_board({v.name, " board_hold"}, bus.stored_array, v.exp_board);
  endtask

  initial begin
    logic [3:0][3:0] m;
    board_t b, e;
    int lat;
    int saw_done;

    reset = 1'b0;
    bus.lock_req = 1'b1;
    bus.piece_mask = '1;
    bus.piece_row = '0;
    bus.piece_col = '0;
    bus.board_in = '1;
    repeat (2) @(posedge clk);
    #1;
    chk_board("reset board", bus.stored_array, '0);
    chk("reset ready", 32'(bus.lock_ready), 32'd1);
    chk("reset done", 32'(bus.lock_done), 32'd0);
    chk("reset flags", {29'd0, bus.overlap_err, bus.oob_err, bus.topout}, 32'd0);
    chk("reset state", 32'(state_dbg), 32'(IDLE));
    bus.lock_req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    m = '0; m[1] = 4'b0110; m[2] = 4'b0110;
    b = '0; e = '0; e[18] = 10'b0000110000; e[19] = 10'b0000110000;
    vecs[0] = mk("opiece", m, 6'sd17, 5'sd3, b, e, 1'b0, 1'b0, 1'b0);
    b[19][4] = 1'b1; b[10] = 10'b1010101010; e[10] = 10'b1010101010;
    vecs[1] = mk("overlap", m, 6'sd17, 5'sd3, b, e, 1'b1, 1'b0, 1'b0);
    m = '0; m[0] = 4'b1111;
    b = '0; e = '0; e[5] = 10'b1100000000;
    vecs[2] = mk("sidewall", m, 6'sd5, 5'sd8, b, e, 1'b0, 1'b1, 1'b0);
    m = '0; m[0] = 4'b0001; m[1] = 4'b0001; m[2] = 4'b0001; m[3] = 4'b0001;
    e = '0; e[0] = 10'b0000000001; e[1] = 10'b0000000001;
    vecs[3] = mk("topout", m, -6'sd2, 5'sd0, b, e, 1'b0, 1'b0, 1'b1);
    m = '0; m[0] = 4'b0001;
    b = '0; b[3] = 10'h155; e = b;
    vecs[4] = mk("corner", m, -6'sd1, -5'sd1, b, e, 1'b0, 1'b1, 1'b1);
    m = '0; m[0] = 4'b0001; m[3] = 4'b0001;
    b = '0; b[0] = 10'h3FF; e = b; e[17] = 10'b0000000001;
    vecs[5] = mk("floor", m, 6'sd17, 5'sd0, b, e, 1'b0, 1'b1, 1'b0);
    m = '0; m[0] = 4'b0011;
    b = '0; b[0] = 10'b0000000001; e = b;
    vecs[6] = mk("leftwall", m, 6'sd0, -5'sd1, b, e, 1'b1, 1'b1, 1'b0);
    m = '0; m[0] = 4'b1111;
    b = '0; e = '0; e[19] = 10'b1111000000;
    vecs[7] = mk("ipiece", m, 6'sd19, 5'sd6, b, e, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_lock(vecs[i], 1'b0, 1'b0, lat);
      check_result(vecs[i], lat);
    end

    // Board changes after accept and a stray request during MERGE must not matter.
    run_lock(vecs[1], 1'b1, 1'b1, lat);
    check_result(vecs[1], lat);
    chk("no_requeue state", 32'(state_dbg), 32'(IDLE));

    // Reset sampled at E2 aborts the lock silently.
    bus.piece_mask = vecs[0].mask;
    bus.piece_row  = vecs[0].prow;
    bus.piece_col  = vecs[0].pcol;
    bus.board_in   = '1;
    bus.lock_req = 1'b1;
    @(posedge clk); #1;
    bus.lock_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.lock_done) saw_done++;
      @(posedge clk); #1;
    end
    chk("midreset done", 32'(saw_done), 32'd0);
    chk_board("midreset board", bus.stored_array, '0);
    chk("midreset flags", {29'd0, bus.overlap_err, bus.oob_err, bus.topout}, 32'd0);
    chk("midreset ready", 32'(bus.lock_ready), 32'd1);

    run_lock(vecs[2], 1'b0, 1'b0, lat);
    check_result(vecs[2], lat);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
